programmable_clock_divider: RTL and testbench

Runtime-programmable successor to the fixed-divisor clock divider. It produces a divided toggle clock and a one-cycle tick enable for the CPU clock domain on the FPGA. It supports a loadable divisor, halt, and, as an option, single-step of one output period for debugging the MIPS core. The block sits between the board oscillator and the processor clock/enable network.

---
 rtl/programmable_clock_divider.sv | 136 +++++++++++++
 tb/tb_programmable_clock_divider.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable clock divider: toggle clock, rising-edge tick, loadable divisor, halt.
// Define CLKDIV_STEP_EN to compile in single-step (one output period) while halted.
module programmable_clock_divider #(
   parameter int          WIDTH           = 28,
   parameter int unsigned DEFAULT_DIVISOR = 1
) (
   input  logic             clockIn,
   input  logic             reset,
   input  logic             halt,
   input  logic             divLoad,
   input  logic [WIDTH-1:0] divIn,
   input  logic             stepReq,
   output logic             clockOut,
   output logic             tickOut,
   output logic             stepBusy,
   output logic [WIDTH-1:0] divisor
);

`ifdef CLKDIV_STEP_EN
   typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;
`else
   typedef enum logic [1:0] {RUN, HALTED} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] counter_q, counter_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             active;
   logic             terminal;

`ifdef CLKDIV_STEP_EN
   logic busy_q, busy_d;
   // Set after the first toggle of a step; the second toggle ends it.
   logic half_q, half_d;
`else
   logic unused_step_req;
   assign unused_step_req = stepReq;
`endif

   always_ff @(posedge clockIn) begin
      if (reset) begin
         state_q   <= RUN;
         counter_q <= '0;
         div_q     <= WIDTH'(DEFAULT_DIVISOR);
         clk_q     <= 1'b0;
         tick_q    <= 1'b0;
`ifdef CLKDIV_STEP_EN
         busy_q    <= 1'b0;
         half_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         div_q     <= div_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
`ifdef CLKDIV_STEP_EN
         busy_q    <= busy_d;
         half_q    <= half_d;
`endif
      end
   end

   assign terminal = (counter_q >= (div_q - WIDTH'(1)));

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      div_d     = div_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      active    = 1'b0;
`ifdef CLKDIV_STEP_EN
      busy_d    = busy_q;
      half_d    = half_q;
`endif

      case (state_q)
         RUN: begin
            if (halt) state_d = HALTED;
            else      active  = 1'b1;
         end
         HALTED: begin
            if (!halt) begin
               state_d = RUN;
`ifdef CLKDIV_STEP_EN
            end else if (stepReq) begin
               state_d = STEP;
               busy_d  = 1'b1;
               half_d  = 1'b0;
`endif
            end
         end
`ifdef CLKDIV_STEP_EN
         STEP: active = 1'b1;
`endif
         default: state_d = RUN;
      endcase

      // A load restarts the half-period and suppresses any toggle this cycle.
      if (divLoad) begin
         div_d     = (divIn == '0) ? WIDTH'(1) : divIn;
         counter_d = '0;
      end else if (active) begin
         if (terminal) begin
            counter_d = '0;
            clk_d     = ~clk_q;
            tick_d    = ~clk_q;
`ifdef CLKDIV_STEP_EN
            if (state_q == STEP) begin
               if (half_q) begin
                  busy_d  = 1'b0;
                  state_d = halt ? HALTED : RUN;
               end else begin
                  half_d = 1'b1;
               end
            end
`endif
         end else begin
            counter_d = counter_q + WIDTH'(1);
         end
      end
   end

   assign clockOut = clk_q;
   assign tickOut  = tick_q;
   assign divisor  = div_q;
`ifdef CLKDIV_STEP_EN
   assign stepBusy = busy_q;
`else
   assign stepBusy = 1'b0;
`endif

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Scoreboard bench for programmable_clock_divider: directed vectors push expectations,
// a negedge monitor pops and compares. Step checks follow CLKDIV_STEP_EN.
module tb_programmable_clock_divider;

   localparam int W = 8;
`ifdef CLKDIV_STEP_EN
   localparam bit S = 1'b1;
`else
   localparam bit S = 1'b0;
`endif

   logic         clk;
   logic         reset, halt, divLoad, stepReq;
   logic [W-1:0] divIn;
   logic         clockOut, tickOut, stepBusy;
   logic [W-1:0] divisor;

   programmable_clock_divider #(.WIDTH(W), .DEFAULT_DIVISOR(1)) dut (
      .clockIn  (clk),
      .reset    (reset),
      .halt     (halt),
      .divLoad  (divLoad),
      .divIn    (divIn),
      .stepReq  (stepReq),
      .clockOut (clockOut),
      .tickOut  (tickOut),
      .stepBusy (stepBusy),
      .divisor  (divisor)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        nm;
      bit           c;
      bit           t;
      bit           b;
      logic [W-1:0] d;
   } exp_t;

   exp_t q[$];
   bit   done = 1'b0;
   int   tests = 0;
   int   fails = 0;

   task automatic cyc(input bit r, input bit h, input bit ld, input logic [W-1:0] din,
                      input bit sr, input bit ec, input bit et, input bit eb,
                      input logic [W-1:0] ed, input string nm);
      exp_t e;
      @(negedge clk);
      reset   = r;
      halt    = h;
      divLoad = ld;
      divIn   = din;
      stepReq = sr;
      @(posedge clk);
      e.nm = nm; e.c = ec; e.t = et; e.b = eb; e.d = ed;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: compares every presented cycle against the head of the scoreboard.
   initial begin
      exp_t e;
      int   budget;
      budget = 0;
      forever begin
         @(negedge clk);
         budget++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, ".clockOut"}, W'(clockOut), W'(e.c));
            chk({e.nm, ".tickOut"},  W'(tickOut),  W'(e.t));
            chk({e.nm, ".stepBusy"}, W'(stepBusy), W'(e.b));
            chk({e.nm, ".divisor"},  divisor,      e.d);
         end else if (done) begin
            break;
         end
         if (budget > 5000) begin
            fails++;
            $display("FAIL cycle_budget: got %0d cycles expected at most 5000", budget);
            break;
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      reset = 1'b1; halt = 1'b0; divLoad = 1'b0; divIn = '0; stepReq = 1'b0;

      // Reset state
      cyc(1, 0, 0, 0, 0,  0, 0, 0, 1, "reset0");
      cyc(1, 0, 0, 0, 0,  0, 0, 0, 1, "reset1");

      // Default divisor 1: toggle every cycle, tick on each rise
      for (int i = 1; i <= 8; i++)
         cyc(0, 0, 0, 0, 0, (i % 2) == 1, (i % 2) == 1, 0, 1, "div1_run");

      // Divisor 5: five cycles per level, tick every ten
      cyc(0, 0, 1, 5, 0,  0, 0, 0, 5, "load5");
      for (int n = 1; n <= 20; n++)
         cyc(0, 0, 0, 0, 0, ((n / 5) % 2) == 1, (n % 10) == 5, 0, 5, "div5_run");

      // divIn 0 clamps to 1
      cyc(0, 0, 1, 0, 0,  0, 0, 0, 1, "load0_clamp");
      cyc(0, 0, 0, 0, 0,  1, 1, 0, 1, "clamp_run_a");
      cyc(0, 0, 0, 0, 0,  0, 0, 0, 1, "clamp_run_b");

      // Divisor 4, halt on second high cycle for 20 cycles
      cyc(0, 0, 1, 4, 0,  0, 0, 0, 4, "load4");
      for (int m = 1; m <= 5; m++)
         cyc(0, 0, 0, 0, 0, m >= 4, m == 4, 0, 4, "div4_pre_halt");
      for (int m = 6; m <= 25; m++)
         cyc(0, 1, 0, 0, 0,  1, 0, 0, 4, "halted");
      cyc(0, 0, 0, 0, 0,  1, 0, 0, 4, "halt_release");
      for (int m = 27; m <= 33; m++)
         cyc(0, 0, 0, 0, 0, (m <= 28) || (m == 33), m == 33, 0, 4, "div4_resume");

      // Load coinciding with terminal count: no toggle, fresh half-period
      for (int m = 34; m <= 36; m++)
         cyc(0, 0, 0, 0, 0,  1, 0, 0, 4, "div4_to_terminal");
      cyc(0, 0, 1, 2, 0,  1, 0, 0, 2, "load_at_terminal");
      cyc(0, 0, 0, 0, 0,  1, 0, 0, 2, "div2_a");
      cyc(0, 0, 0, 0, 0,  0, 0, 0, 2, "div2_b");
      cyc(0, 0, 0, 0, 0,  0, 0, 0, 2, "div2_c");
      cyc(0, 0, 0, 0, 0,  1, 1, 0, 2, "div2_d");

      // Single step with divisor 3 while halted; second request ignored
      cyc(0, 1, 1, 3, 0,  1, 0, 0, 3, "load3_halting");
      cyc(0, 1, 0, 0, 1,  1, 0, S, 3, "step_req");
      cyc(0, 1, 0, 0, 0,  1, 0, S, 3, "step_c1");
      cyc(0, 1, 0, 0, 1,  1, 0, S, 3, "step_c2_req_ignored");
      for (int k = 3; k <= 5; k++)
         cyc(0, 1, 0, 0, 0,  !S, 0, S, 3, "step_low");
      cyc(0, 1, 0, 0, 0,  1, S, 0, 3, "step_done");
      for (int k = 7; k <= 9; k++)
         cyc(0, 1, 0, 0, 0,  1, 0, 0, 3, "step_frozen_after");

      // Reset in the middle of a step
      cyc(0, 1, 0, 0, 1,  1, 0, S, 3, "step2_req");
      cyc(0, 1, 0, 0, 0,  1, 0, S, 3, "step2_c1");
      cyc(1, 1, 0, 0, 0,  0, 0, 0, 1, "reset_mid_step");
      cyc(0, 0, 0, 0, 0,  1, 1, 0, 1, "run_after_reset_a");
      cyc(0, 0, 0, 0, 0,  0, 0, 0, 1, "run_after_reset_b");

      done = 1'b1;
   end

endmodule
